// File: rtl/slot_embed_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : slot_embed_if
//  Description : Bus bundle between the slot-embedding engine and its
//                controller / two-bank FFT buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface slot_embed_if #(
    parameter int LOGN         = 13,
    parameter int FLP_WORDSIZE = 64
);
    logic                        start;
    logic [1:0]                  current_n;
    logic [LOGN-2:0]             fft_rd_addr;
    logic [2*FLP_WORDSIZE-1:0]   fft_bank0_rd_data;
    logic [2*FLP_WORDSIZE-1:0]   fft_bank1_rd_data;
    logic [LOGN-2:0]             fft_wr_addr;
    logic                        fft_bank0_wea;
    logic                        fft_bank1_wea;
    logic [2*FLP_WORDSIZE-1:0]   fft_wr_data;
    logic                        busy;
    logic                        done;

    // Engine side
    modport slave (
        input  start, current_n, fft_bank0_rd_data, fft_bank1_rd_data,
        output fft_rd_addr, fft_wr_addr, fft_bank0_wea, fft_bank1_wea,
               fft_wr_data, busy, done
    );

    // Controller / buffer side
    modport master (
        output start, current_n, fft_bank0_rd_data, fft_bank1_rd_data,
        input  fft_rd_addr, fft_wr_addr, fft_bank0_wea, fft_bank1_wea,
               fft_wr_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/slot_embed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : slot_embed
//  Description : Scatters S = L/2 sequential slot values from the upper half
//                of the two-bank FFT buffer into their folded canonical-
//                embedding positions (3^s mod 2L) in the lower half,
//                conjugating values that land in the mirrored half.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_embed #(
    parameter int LOGN         = 13,
    parameter int FLP_WORDSIZE = 64,
    parameter int BRAM_RD_LAT  = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    slot_embed_if.slave  bus
);

    localparam int c_AW = LOGN - 1;                  // buffer word address width
    localparam int c_PW = LOGN + 1;                  // power register width
    localparam int c_W  = FLP_WORDSIZE;
    localparam int c_DW = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(BRAM_RD_LAT - 1);
    localparam logic [c_PW-1:0] c_POW_ONE    = c_PW'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         r_rshift;        // LOGN - log2(L) for the current run
    logic [c_AW-1:0]    r_slot;
    logic [c_PW-1:0]    r_pow;
    logic [c_DW-1:0]    r_drain;
    logic               r_busy;
    logic               r_done;

    // Position/bank/conjugate pipeline, aligned with the memory read latency
    logic [BRAM_RD_LAT-1:0] r_pv;
    logic [BRAM_RD_LAT-1:0] r_pconj;
    logic [BRAM_RD_LAT-1:0] r_psrc;
    logic [c_AW-1:0]        r_pfold [BRAM_RD_LAT];

    logic [1:0]         w_rshift_in;
    logic [c_PW-1:0]    w_pmask;
    logic [c_AW-1:0]    w_last;          // S-1, also the fold mask
    logic [LOGN-1:0]    w_half;          // L/2
    logic [LOGN-1:0]    w_j;
    logic [LOGN-1:0]    w_jrev;
    logic [LOGN-1:0]    w_idx;
    logic               w_conj;
    logic [c_AW-1:0]    w_fold;
    logic [c_PW-1:0]    w_pow3;
    logic               w_accept;
    logic               w_wv;
    logic [c_AW-1:0]    w_wfold;
    logic [2*c_W-1:0]   w_src_word;

    // Size select: how far the full-size quantities shift down for this L
    always_comb begin
        w_rshift_in = 2'd0;
        case (bus.current_n)
            2'd0:    w_rshift_in = 2'd2;
            2'd1:    w_rshift_in = 2'd1;
            default: w_rshift_in = 2'd0;
        endcase
    end

    assign w_pmask = {c_PW{1'b1}} >> r_rshift;
    assign w_last  = {c_AW{1'b1}} >> r_rshift;
    assign w_half  = {1'b1, {(LOGN-1){1'b0}}} >> r_rshift;

    // p is always odd, so (p-1)>>1 is just p>>1
    assign w_j = r_pow[LOGN:1];

    // Reverse over LOGN bits, then shift down to reverse over log2(L) bits
    always_comb begin
        w_jrev = '0;
        for (int i = 0; i < LOGN; i++) begin
            w_jrev[i] = w_j[LOGN-1-i];
        end
    end

    assign w_idx  = w_jrev >> r_rshift;
    assign w_conj = |(w_idx & w_half);
    // L-1-idx equals the complement of idx within the lower log2(L)-1 bits
    assign w_fold = w_conj ? (w_last & ~w_idx[c_AW-1:0]) : w_idx[c_AW-1:0];

    assign w_pow3   = (r_pow << 1) + r_pow;
    assign w_accept = bus.start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // Control FSM: slot counter, power register, drain and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_rshift <= 2'd0;
            r_slot   <= '0;
            r_pow    <= c_POW_ONE;
            r_drain  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_accept) begin
                        r_state  <= c_ST_RUN;
                        r_rshift <= w_rshift_in;
                        r_slot   <= '0;
                        r_pow    <= c_POW_ONE;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    r_slot <= r_slot + 1'b1;
                    r_pow  <= w_pow3 & w_pmask;
                    if (r_slot == w_last) begin
                        r_state <= c_ST_DRAIN;
                        r_drain <= '0;
                    end
                end
                c_ST_DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (r_drain == c_DRAIN_LAST) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Carry each slot's destination alongside its outstanding read; reset flushes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv    <= '0;
            r_pconj <= '0;
            r_psrc  <= '0;
            for (int k = 0; k < BRAM_RD_LAT; k++) begin
                r_pfold[k] <= '0;
            end
        end else begin
            r_pv[0]    <= (r_state == c_ST_RUN);
            r_pconj[0] <= w_conj;
            r_psrc[0]  <= r_slot[0];
            r_pfold[0] <= w_fold;
            for (int k = 1; k < BRAM_RD_LAT; k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_pconj[k] <= r_pconj[k-1];
                r_psrc[k]  <= r_psrc[k-1];
                r_pfold[k] <= r_pfold[k-1];
            end
        end
    end

    assign w_wv       = r_pv[BRAM_RD_LAT-1];
    assign w_wfold    = r_pfold[BRAM_RD_LAT-1];
    assign w_src_word = r_psrc[BRAM_RD_LAT-1] ? bus.fft_bank1_rd_data : bus.fft_bank0_rd_data;

    // Sources live in the upper half, destinations in the lower half
    assign bus.fft_rd_addr   = (r_state == c_ST_RUN) ? {1'b1, r_slot[c_AW-1:1]} : '0;
    assign bus.fft_wr_addr   = w_wv ? {1'b0, w_wfold[c_AW-1:1]} : '0;
    assign bus.fft_bank0_wea = w_wv & ~w_wfold[0];
    assign bus.fft_bank1_wea = w_wv &  w_wfold[0];
    assign bus.fft_wr_data   = w_wv ? {w_src_word[2*c_W-1:c_W],
                                       w_src_word[c_W-1] ^ r_pconj[BRAM_RD_LAT-1],
                                       w_src_word[c_W-2:0]} : '0;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_slot_embed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_slot_embed
//  Description : Directed self-checking bench for slot_embed with a two-bank
//                read-latency buffer model and a slot-position reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_embed;

    localparam int LOGN  = 13;
    localparam int W     = 64;
    localparam int LAT   = 2;
    localparam int UBASE = 1 << (LOGN - 2);

    typedef struct {
        int          bank;
        int          addr;
        logic [127:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   both_cnt = 0;
    int   nobusy_wr = 0;
    wr_t  wlog[$];
    wr_t  ref_n0[$];
    wr_t  ref_n2[$];
    wr_t  refq[$];

    logic [127:0] r0_d1, r0_d2, r1_d1, r1_d2;

    always #5 clk = ~clk;

    slot_embed_if #(.LOGN(LOGN), .FLP_WORDSIZE(W)) bus ();

    slot_embed #(.LOGN(LOGN), .FLP_WORDSIZE(W), .BRAM_RD_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [127:0] src_word(input int b, input int a);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        return {16'hA5A5, bv[15:0], av, (av[1] ^ bv[0]), 15'h1234, bv[15:0], av * 32'd7};
    endfunction

    // Buffer model: upper-half contents are a fixed function of bank/address
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        r0_d1 <= src_word(0, int'(bus.fft_rd_addr));
        r1_d1 <= src_word(1, int'(bus.fft_rd_addr));
        r0_d2 <= r0_d1;
        r1_d2 <= r1_d1;
    end
    assign bus.fft_bank0_rd_data = r0_d2;
    assign bus.fft_bank1_rd_data = r1_d2;

    // Write monitor
    always @(negedge clk) begin
        wr_t e;
        if (bus.fft_bank0_wea || bus.fft_bank1_wea) begin
            e.bank = bus.fft_bank1_wea ? 1 : 0;
            e.addr = int'(bus.fft_wr_addr);
            e.data = bus.fft_wr_data;
            wlog.push_back(e);
            if (bus.fft_bank0_wea && bus.fft_bank1_wea) both_cnt <= both_cnt + 1;
            if (!bus.busy) nobusy_wr <= nobusy_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] n, output int t0);
        @(negedge clk);
        bus.current_n = n;
        bus.start     = 1'b1;
        t0            = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_done_seen"}, 128'(bus.done), 128'(1));
    endtask

    // Reference: slot s -> 3^s mod 2L -> bit-reversed index -> folded position
    task automatic score(input int l, input string tag);
        int lg, p, j, idx, fold, mism, bad;
        bit conj;
        logic [127:0] ed;
        int hits[];
        lg   = $clog2(l);
        hits = new[l/2];
        p    = 1;
        mism = 0;
        bad  = 0;
        check({tag, "_count"}, 128'(wlog.size()), 128'(l/2));
        for (int s = 0; s < l/2 && s < wlog.size(); s++) begin
            j   = (p - 1) / 2;
            idx = 0;
            for (int k = 0; k < lg; k++) if (j[k]) idx = idx | (1 << (lg - 1 - k));
            if (idx < l/2) begin fold = idx; conj = 1'b0; end
            else begin fold = l - 1 - idx; conj = 1'b1; end
            ed = src_word(s % 2, UBASE + s / 2);
            if (conj) ed[63] = ~ed[63];
            if (wlog[s].bank != fold % 2 || wlog[s].addr != fold / 2 || wlog[s].data !== ed) begin
                if (mism < 3)
                    $display("  %s slot %0d: got bank %0d addr %0d data %h, want bank %0d addr %0d data %h",
                             tag, s, wlog[s].bank, wlog[s].addr, wlog[s].data, fold % 2, fold / 2, ed);
                mism++;
            end
            hits[fold]++;
            p = (p * 3) % (2 * l);
        end
        for (int f = 0; f < l/2; f++) if (hits[f] != 1) bad++;
        check({tag, "_values"}, 128'(mism), 128'(0));
        check({tag, "_coverage"}, 128'(bad), 128'(0));
    endtask

    task automatic cmp_ref(input string tag);
        int m;
        m = 0;
        if (wlog.size() != refq.size()) m++;
        for (int i = 0; i < wlog.size() && i < refq.size(); i++)
            if (wlog[i].bank != refq[i].bank || wlog[i].addr != refq[i].addr ||
                wlog[i].data !== refq[i].data) m++;
        check(tag, 128'(m), 128'(0));
    endtask

    initial begin
        int t0, at;
        logic [127:0] ed;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.current_n = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",    128'(bus.busy), 128'(0));
        check("rst_done",    128'(bus.done), 128'(0));
        check("rst_wea0",    128'(bus.fft_bank0_wea), 128'(0));
        check("rst_wea1",    128'(bus.fft_bank1_wea), 128'(0));
        check("rst_rd_addr", 128'(bus.fft_rd_addr), 128'(0));
        check("rst_wr_addr", 128'(bus.fft_wr_addr), 128'(0));
        check("rst_wr_data", bus.fft_wr_data, 128'(0));
        rst = 1'b0;

        // L = 2048
        wlog.delete();
        do_start(2'd0, t0);
        check("n0_busy_run", 128'(bus.busy), 128'(1));
        check("n0_rd_addr0", 128'(bus.fft_rd_addr), 128'(UBASE));
        wait_done(1100, "n0", at);
        check("n0_latency", 128'(at - t0), 128'(1 + 1024 + LAT));
        check("n0_busy_end", 128'(bus.busy), 128'(0));
        check("n0_s0_bank", 128'(wlog[0].bank), 128'(0));
        check("n0_s0_addr", 128'(wlog[0].addr), 128'(0));
        check("n0_s0_data", wlog[0].data, src_word(0, UBASE));
        ed = src_word(1, UBASE);
        ed[63] = ~ed[63];
        check("n0_s1_bank", 128'(wlog[1].bank), 128'(1));
        check("n0_s1_addr", 128'(wlog[1].addr), 128'(511));
        check("n0_s1_data", wlog[1].data, ed);
        check("n0_s2_bank", 128'(wlog[2].bank), 128'(0));
        check("n0_s2_addr", 128'(wlog[2].addr), 128'(128));
        check("n0_s2_data", wlog[2].data, src_word(0, UBASE + 1));
        score(2048, "n0");
        ref_n0 = wlog;

        // L = 8192
        wlog.delete();
        do_start(2'd2, t0);
        wait_done(4200, "n2", at);
        check("n2_latency", 128'(at - t0), 128'(1 + 4096 + LAT));
        ed = src_word(1, UBASE);
        ed[63] = ~ed[63];
        check("n2_s1_bank", 128'(wlog[1].bank), 128'(1));
        check("n2_s1_addr", 128'(wlog[1].addr), 128'(2047));
        check("n2_s1_data", wlog[1].data, ed);
        score(8192, "n2");
        ref_n2 = wlog;

        // Reset at RUN cycle 10
        wlog.delete();
        do_start(2'd0, t0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_wea0", 128'(bus.fft_bank0_wea), 128'(0));
        check("mrst_wea1", 128'(bus.fft_bank1_wea), 128'(0));
        check("mrst_busy", 128'(bus.busy), 128'(0));
        check("mrst_done", 128'(bus.done), 128'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mrst_writes", 128'(wlog.size()), 128'(9));
        check("mrst_idle_busy", 128'(bus.busy), 128'(0));

        // start during RUN is ignored
        wlog.delete();
        do_start(2'd0, t0);
        repeat (5) @(negedge clk);
        bus.start     = 1'b1;
        bus.current_n = 2'd2;
        @(negedge clk);
        bus.start     = 1'b0;
        wait_done(1100, "ign", at);
        check("ign_latency", 128'(at - t0), 128'(1 + 1024 + LAT));
        score(2048, "ign");
        refq = ref_n0;
        cmp_ref("ign_seq");

        // start in DONE restarts
        wlog.delete();
        do_start(2'd0, t0);
        check("rs_done_drop", 128'(bus.done), 128'(0));
        check("rs_busy", 128'(bus.busy), 128'(1));
        wait_done(1100, "rs", at);
        check("rs_latency", 128'(at - t0), 128'(1 + 1024 + LAT));
        cmp_ref("rs_seq");

        // current_n = 3 matches current_n = 2; mid-run size change ignored
        wlog.delete();
        do_start(2'd3, t0);
        repeat (100) @(negedge clk);
        bus.current_n = 2'd0;
        wait_done(4200, "n3", at);
        check("n3_latency", 128'(at - t0), 128'(1 + 4096 + LAT));
        refq = ref_n2;
        cmp_ref("n3_seq");

        check("both_banks_written", 128'(both_cnt), 128'(0));
        check("write_outside_busy", 128'(nobusy_wr), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
